qea_engine: RTL and testbench
=============================

Name: qea_engine

Overview:
Quantum-emulation accelerator (QEA) for state-vector simulation. It holds an n-qubit complex state vector in an on-chip state RAM, PE_NUM amplitudes per row. A gate program is loaded into a context RAM; on start, the program's 2x2 (optionally controlled) unitaries are applied in order. It raises o_complete when finished. The host loads the state, starts execution, then reads the state back through one wide port.

Parameters:
PE_NUM_WIDTH, 2, log2(PE_NUM).
PE_NUM, 4, amplitudes per state-RAM row (lanes).
DATA_WIDTH, 32, width of one real/imag component.
MAX_QBIT_WIDTH, 6, width of i_qbit_num.
ALU_DATA_WIDTH, DATA_WIDTH, multiplier operand width.
STATE_DATA_WIDTH, 2*DATA_WIDTH, one complex amplitude {re,im}.
STATE_ADDR_WIDTH, 16, state-RAM row address width.
GATE_DATA_WIDTH, 2*DATA_WIDTH, one matrix element {re,im}.
GATE_ADDR_WIDTH, 6, width of internal gate-register index (>=3).
GATE_CONTEXT_DATA_WIDTH, 2*DATA_WIDTH, context word width.
GATE_CONTEXT_ADDR_WIDTH, 16, context-RAM address width.
NUM_FRAC_BIT, 30, fractional bits, signed fixed point (0x40000000 = 1.0).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous, active-high reset (reset when 1, despite the name).
i_start  in  1  one-cycle start pulse; honoured only when idle.
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count n, PE_NUM_WIDTH <= n <= STATE_ADDR_WIDTH+PE_NUM_WIDTH.
i_ctx_en / i_ctx_wea  in  1 / 1  context-RAM enable and write.
i_ctx_addr  in  GATE_CONTEXT_ADDR_WIDTH  context address.
i_ctx_data  in  GATE_CONTEXT_DATA_WIDTH  context write data.
i_state_ena / i_state_wea  in  PE_NUM / PE_NUM  per-lane enable and write.
i_state_addra  in  STATE_ADDR_WIDTH  state row address.
i_state_dina  in  PE_NUM*STATE_DATA_WIDTH  row write data.
o_complete  out  1  program finished.
o_state_dout  out  PE_NUM*STATE_DATA_WIDTH  row read data.

Behaviour:
- Row layout: lane k occupies bits [(PE_NUM-k)*64-1 -: 64], so lane 0 is the MSB slice. Amplitude index = row*PE_NUM + lane. Row {re[63:32], im[31:0]}, two's complement.
- Host state port, idle only: read-first. o_state_dout (enabled lanes) = old contents one cycle after ena. Write lands the same edge. Ignored while busy.
- Host ctx port: writes take effect when idle; ignored while busy.
- Program format: gate = header word + 4 words U00,U01,U10,U11 ({re,im}).
  - Header: op[63:60] (0 END, 1 single-qubit, 2 controlled).
  - Header: target[53:48], control[45:40].
  - Unknown op is treated as END.
- FSM: IDLE -> FETCH (header + 4 matrix words, 1-cycle ctx read latency) -> pair loop (RD0, RD1, CALC, WR0, WR1) -> next gate FETCH, or DONE on END.
- DONE: o_complete=1, held until the next accepted i_start clears it.
- Pair loop: for every index i0 with target bit 0, set i1 = i0 | (1<<target). Skip the pair if op=2 and bit control of i0 is 0.
  - Compute a0' = U00*a0 + U01*a1 and a1' = U10*a0 + U11*a1.
  - Complex products are full 64-bit. Sums are arithmetic-shifted right by NUM_FRAC_BIT and truncated to 32 bits (wrap).
  - If target < PE_NUM_WIDTH, both amplitudes share one row: one read, one write.
- Reset: FSM IDLE, o_complete=0, o_state_dout=0. RAM contents are not cleared. Reset mid-run aborts immediately.
- i_start while busy is ignored. An END at address 0 gives DONE with the state unchanged.

Optional Feature:
QEA_SATURATE_EN. When defined, each 32-bit component result saturates to 0x7FFFFFFF/0x80000000 on overflow. When undefined, results wrap (two's complement truncation).

Decomposition:
- Package qea_pkg: opcode constants, header field positions, FSM state enum, complex {re,im} typedef.
- One sub-module, qea_cmac: 2x2 complex multiply-accumulate producing a0', a1' with the shift/truncate rule.

Test Plan:
1. Reset asserted 3 cycles -> o_complete=0, o_state_dout=0; i_start during reset ignored.
2. n=3, amp0 = 0x40000000_00000000 (lane 0, row 0). Program H on q0 (U=0x2D413CCC, U11=-0x2D413CCC), then END. Read row 0 -> lanes 0,1 = 0x2D413CCC_00000000, lanes 2,3 = 0.
3. n=3, amp0 = 1.0. Program X on q2, then END. Read -> row 0 all zero; row 1 lane 0 = 0x40000000_00000000.
4. n=3, amp3 = 1.0. Controlled-phase op=2, control 0, target 1, U11=i (0x00000000_40000000), then END. Read -> lane 3 = 0x00000000_40000000.
5. Program word 0 = END -> o_complete=1 within 4 cycles of i_start; state unchanged; o_complete cleared on the next i_start.
6. Readout with wea=all-ones and dina=0 -> o_state_dout shows the pre-write values; a second readout pass returns zeros.

Source files
------------

// File: rtl/qea_pkg.sv
// Shared definitions for the QEA state-vector engine: opcodes, gate-header field
// positions, controller states and the complex amplitude layout.
package qea_pkg;

    localparam int QEA_DW = 32;

    localparam logic [3:0] OP_END    = 4'd0;
    localparam logic [3:0] OP_SINGLE = 4'd1;
    localparam logic [3:0] OP_CTRL   = 4'd2;

    localparam int HDR_OP_MSB  = 63;
    localparam int HDR_OP_LSB  = 60;
    localparam int HDR_TGT_MSB = 53;
    localparam int HDR_TGT_LSB = 48;
    localparam int HDR_CTL_MSB = 45;
    localparam int HDR_CTL_LSB = 40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RD0,
        S_RD1,
        S_CALC,
        S_WR0,
        S_WR1,
        S_DONE
    } qea_state_e;

    typedef struct packed {
        logic signed [QEA_DW-1:0] re;
        logic signed [QEA_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/qea_cmac.sv
// 2x2 complex multiply-accumulate: a0' = ua*a0 + ub*a1 in signed fixed point.
// QEA_SATURATE_EN selects saturating instead of wrapping component results.
module qea_cmac #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_FRAC_BIT = 30
) (
    input  logic [2*DATA_WIDTH-1:0] u00_i,
    input  logic [2*DATA_WIDTH-1:0] u01_i,
    input  logic [2*DATA_WIDTH-1:0] u10_i,
    input  logic [2*DATA_WIDTH-1:0] u11_i,
    input  logic [2*DATA_WIDTH-1:0] a0_i,
    input  logic [2*DATA_WIDTH-1:0] a1_i,
    output logic [2*DATA_WIDTH-1:0] a0_o,
    output logic [2*DATA_WIDTH-1:0] a1_o
);

    // Three guard bits above the full product hold a four-term sum exactly.
    localparam int ACC_W = 2*DATA_WIDTH + 3;

    typedef logic signed [DATA_WIDTH-1:0] comp_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

`ifdef QEA_SATURATE_EN
    localparam acc_t SAT_MAX = acc_t'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam acc_t SAT_MIN = -SAT_MAX - acc_t'(1);
`endif

    function automatic acc_t mul(input comp_t x, input comp_t y);
        acc_t xe;
        acc_t ye;
        xe = acc_t'(x);
        ye = acc_t'(y);
        return xe * ye;
    endfunction

    function automatic comp_t fit(input acc_t s);
        acc_t sh;
        sh = s >>> NUM_FRAC_BIT;
`ifdef QEA_SATURATE_EN
        if (sh > SAT_MAX) begin
            return comp_t'(SAT_MAX);
        end
        if (sh < SAT_MIN) begin
            return comp_t'(SAT_MIN);
        end
`endif
        return sh[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [2*DATA_WIDTH-1:0] cmac2(
        input logic [2*DATA_WIDTH-1:0] ua,
        input logic [2*DATA_WIDTH-1:0] xa,
        input logic [2*DATA_WIDTH-1:0] ub,
        input logic [2*DATA_WIDTH-1:0] xb
    );
        comp_t uar, uai, xar, xai, ubr, ubi, xbr, xbi;
        acc_t  re, im;
        uar = ua[2*DATA_WIDTH-1:DATA_WIDTH];
        uai = ua[DATA_WIDTH-1:0];
        xar = xa[2*DATA_WIDTH-1:DATA_WIDTH];
        xai = xa[DATA_WIDTH-1:0];
        ubr = ub[2*DATA_WIDTH-1:DATA_WIDTH];
        ubi = ub[DATA_WIDTH-1:0];
        xbr = xb[2*DATA_WIDTH-1:DATA_WIDTH];
        xbi = xb[DATA_WIDTH-1:0];
        re = mul(uar, xar) - mul(uai, xai) + mul(ubr, xbr) - mul(ubi, xbi);
        im = mul(uar, xai) + mul(uai, xar) + mul(ubr, xbi) + mul(ubi, xbr);
        return {fit(re), fit(im)};
    endfunction

    assign a0_o = cmac2(u00_i, a0_i, u01_i, a1_i);
    assign a1_o = cmac2(u10_i, a0_i, u11_i, a1_i);

endmodule

// File: rtl/qea_engine.sv
// QEA top: state RAM, gate-program context RAM and the gate-application controller.
// Define QEA_SATURATE_EN to saturate amplitude components instead of wrapping.
module qea_engine
    import qea_pkg::*;
#(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
    parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
    parameter int GATE_ADDR_WIDTH         = 6,
    parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int NUM_FRAC_BIT            = 30
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic                                 i_ctx_en,
    input  logic                                 i_ctx_wea,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic [PE_NUM-1:0]                    i_state_ena,
    input  logic [PE_NUM-1:0]                    i_state_wea,
    input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
    output logic                                 o_complete,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

    localparam int IDX_W       = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int STATE_DEPTH = 1 << STATE_ADDR_WIDTH;
    localparam int CTX_DEPTH   = 1 << GATE_CONTEXT_ADDR_WIDTH;

    logic [STATE_DATA_WIDTH-1:0]        state_mem [STATE_DEPTH][PE_NUM];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_mem   [CTX_DEPTH];

    qea_state_e                         state_q, state_d;
    logic [2:0]                         fcnt_q, fcnt_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [IDX_W-1:0]                   pair_q, pair_d;
    logic [MAX_QBIT_WIDTH-1:0]          qn_q;
    logic [3:0]                         op_q;
    logic [GATE_ADDR_WIDTH-1:0]         tgt_q, ctl_q;
    logic [GATE_DATA_WIDTH-1:0]         u_q [4];
    cplx_t                              a0_q, r0_q, r1_q;
    logic [STATE_DATA_WIDTH-1:0]        rdata_q [PE_NUM];
    logic [STATE_DATA_WIDTH-1:0]        dout_q  [PE_NUM];
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_rdata_q;

    logic                               host_idle;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_raddr;
    logic [IDX_W-1:0]                   low_mask, idx0, idx1, pair_last;
    logic [STATE_ADDR_WIDTH-1:0]        row0, row1;
    logic [PE_NUM_WIDTH-1:0]            lane0, lane1;
    logic                               same_row, ctl_bit, skip, last_pair, advance;
    logic [3:0]                         hdr_op;
    logic                               hdr_valid;
    logic [STATE_ADDR_WIDTH-1:0]        ram_addr;
    logic                               ram_rd;
    logic [PE_NUM-1:0]                  ram_we;
    logic [STATE_DATA_WIDTH-1:0]        ram_wdata [PE_NUM];
    logic [STATE_DATA_WIDTH-1:0]        cmac_a0_in, cmac_a1_in, cmac_a0_out, cmac_a1_out;

    assign host_idle = (state_q == S_IDLE) || (state_q == S_DONE);
    assign o_complete = (state_q == S_DONE);
    assign ctx_raddr = pc_q + GATE_CONTEXT_ADDR_WIDTH'(fcnt_q);
    assign hdr_op    = ctx_rdata_q[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_valid = (hdr_op == OP_SINGLE) || (hdr_op == OP_CTRL);

    // Pair index i0 is the pair counter with a zero inserted at the target bit.
    assign low_mask  = (IDX_W'(1) << tgt_q) - IDX_W'(1);
    assign idx0      = ((pair_q & ~low_mask) << 1) | (pair_q & low_mask);
    assign idx1      = idx0 | (IDX_W'(1) << tgt_q);
    assign pair_last = (IDX_W'(1) << (qn_q - MAX_QBIT_WIDTH'(1))) - IDX_W'(1);
    assign row0      = idx0[IDX_W-1:PE_NUM_WIDTH];
    assign row1      = idx1[IDX_W-1:PE_NUM_WIDTH];
    assign lane0     = idx0[PE_NUM_WIDTH-1:0];
    assign lane1     = idx1[PE_NUM_WIDTH-1:0];
    assign same_row  = (tgt_q < GATE_ADDR_WIDTH'(PE_NUM_WIDTH));
    assign ctl_bit   = |((idx0 >> ctl_q) & IDX_W'(1));
    assign skip      = (op_q == OP_CTRL) && !ctl_bit;
    assign last_pair = (pair_q == pair_last);

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pc_d     = pc_q;
        pair_d   = pair_q;
        ram_addr = i_state_addra;
        ram_rd   = 1'b0;
        ram_we   = '0;
        advance  = 1'b0;
        for (int k = 0; k < PE_NUM; k++) begin
            ram_wdata[k] = i_state_dina[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH];
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                ram_we = i_state_ena & i_state_wea;
                if (i_start) begin
                    state_d = S_FETCH;
                    fcnt_d  = '0;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                fcnt_d = fcnt_q + 3'd1;
                if (fcnt_q == 3'd1 && !hdr_valid) begin
                    state_d = S_DONE;
                end else if (fcnt_q == 3'd5) begin
                    state_d = S_RD0;
                    fcnt_d  = '0;
                    pair_d  = '0;
                    pc_d    = pc_q + GATE_CONTEXT_ADDR_WIDTH'(5);
                end
            end
            S_RD0: begin
                if (skip) begin
                    advance = 1'b1;
                end else begin
                    ram_addr = row0;
                    ram_rd   = 1'b1;
                    state_d  = same_row ? S_CALC : S_RD1;
                end
            end
            S_RD1: begin
                ram_addr = row1;
                ram_rd   = 1'b1;
                state_d  = S_CALC;
            end
            S_CALC: begin
                state_d = S_WR0;
            end
            S_WR0: begin
                ram_addr         = row0;
                ram_we[lane0]    = 1'b1;
                ram_wdata[lane0] = r0_q;
                if (same_row) begin
                    ram_we[lane1]    = 1'b1;
                    ram_wdata[lane1] = r1_q;
                    advance          = 1'b1;
                end else begin
                    state_d = S_WR1;
                end
            end
            S_WR1: begin
                ram_addr         = row1;
                ram_we[lane1]    = 1'b1;
                ram_wdata[lane1] = r1_q;
                advance          = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (last_pair) begin
                state_d = S_FETCH;
                fcnt_d  = '0;
            end else begin
                pair_d  = pair_q + IDX_W'(1);
                state_d = S_RD0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pc_q    <= '0;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pc_q    <= pc_d;
            pair_q  <= pair_d;
        end
    end

    always_ff @(posedge clk) begin
        if (host_idle && i_start) begin
            qn_q <= i_qbit_num;
        end
        if (state_q == S_FETCH) begin
            if (fcnt_q == 3'd1) begin
                op_q  <= hdr_op;
                tgt_q <= ctx_rdata_q[HDR_TGT_MSB:HDR_TGT_LSB];
                ctl_q <= ctx_rdata_q[HDR_CTL_MSB:HDR_CTL_LSB];
            end else if (fcnt_q >= 3'd2) begin
                // fcnt 2..5 map onto U00..U11 through the low two bits.
                u_q[fcnt_q[1:0] - 2'd2] <= ctx_rdata_q;
            end
        end
        if (state_q == S_RD1) begin
            a0_q <= rdata_q[lane0];
        end
        if (state_q == S_CALC) begin
            r0_q <= cmac_a0_out;
            r1_q <= cmac_a1_out;
        end
    end

    assign cmac_a0_in = same_row ? rdata_q[lane0] : a0_q;
    assign cmac_a1_in = rdata_q[lane1];

    qea_cmac #(
        .DATA_WIDTH   (ALU_DATA_WIDTH),
        .NUM_FRAC_BIT (NUM_FRAC_BIT)
    ) u_cmac (
        .u00_i (u_q[0]),
        .u01_i (u_q[1]),
        .u10_i (u_q[2]),
        .u11_i (u_q[3]),
        .a0_i  (cmac_a0_in),
        .a1_i  (cmac_a1_in),
        .a0_o  (cmac_a0_out),
        .a1_o  (cmac_a1_out)
    );

    always_ff @(posedge clk) begin
        if (ram_rd) begin
            for (int k = 0; k < PE_NUM; k++) begin
                rdata_q[k] <= state_mem[ram_addr][k];
            end
        end
        for (int k = 0; k < PE_NUM; k++) begin
            if (ram_we[k]) begin
                state_mem[ram_addr][k] <= ram_wdata[k];
            end
        end
    end

    // Host readout is read-first: the same edge may overwrite the row.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < PE_NUM; k++) begin
                dout_q[k] <= '0;
            end
        end else if (host_idle) begin
            for (int k = 0; k < PE_NUM; k++) begin
                if (i_state_ena[k]) begin
                    dout_q[k] <= state_mem[i_state_addra][k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_FETCH) begin
            ctx_rdata_q <= ctx_mem[ctx_raddr];
        end
        if (host_idle && i_ctx_en && i_ctx_wea) begin
            ctx_mem[i_ctx_addr] <= i_ctx_data;
        end
    end

    for (genvar k = 0; k < PE_NUM; k++) begin : g_lane
        assign o_state_dout[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH] = dout_q[k];
    end

endmodule

// File: tb/tb_qea_engine.sv
// Directed bench for qea_engine: reset, H / X / controlled-phase gates, END program
// and read-first destructive readout.
module tb_qea_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_start;
    logic [5:0]   i_qbit_num;
    logic         i_ctx_en;
    logic         i_ctx_wea;
    logic [15:0]  i_ctx_addr;
    logic [63:0]  i_ctx_data;
    logic [3:0]   i_state_ena;
    logic [3:0]   i_state_wea;
    logic [15:0]  i_state_addra;
    logic [255:0] i_state_dina;
    logic         o_complete;
    logic [255:0] o_state_dout;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] ONE = 64'h40000000_00000000;
    localparam logic [63:0] HP  = 64'h2D413CCC_00000000;
    localparam logic [63:0] HN  = 64'hD2BEC334_00000000;
    localparam logic [63:0] IMG = 64'h00000000_40000000;
    localparam logic [63:0] Z   = 64'h0;

    qea_engine dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_qbit_num    (i_qbit_num),
        .i_ctx_en      (i_ctx_en),
        .i_ctx_wea     (i_ctx_wea),
        .i_ctx_addr    (i_ctx_addr),
        .i_ctx_data    (i_ctx_data),
        .i_state_ena   (i_state_ena),
        .i_state_wea   (i_state_wea),
        .i_state_addra (i_state_addra),
        .i_state_dina  (i_state_dina),
        .o_complete    (o_complete),
        .o_state_dout  (o_state_dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr_ctx(input logic [15:0] addr, input logic [63:0] data);
        i_ctx_en   = 1'b1;
        i_ctx_wea  = 1'b1;
        i_ctx_addr = addr;
        i_ctx_data = data;
        tick();
        i_ctx_en   = 1'b0;
        i_ctx_wea  = 1'b0;
    endtask

    task automatic load_gate(input logic [63:0] hdr, input logic [63:0] u00, input logic [63:0] u01,
                             input logic [63:0] u10, input logic [63:0] u11);
        wr_ctx(16'd0, hdr);
        wr_ctx(16'd1, u00);
        wr_ctx(16'd2, u01);
        wr_ctx(16'd3, u10);
        wr_ctx(16'd4, u11);
        wr_ctx(16'd5, 64'h0);
    endtask

    task automatic wr_row(input logic [15:0] addr, input logic [255:0] data);
        i_state_ena   = 4'hF;
        i_state_wea   = 4'hF;
        i_state_addra = addr;
        i_state_dina  = data;
        tick();
        i_state_ena   = 4'h0;
        i_state_wea   = 4'h0;
    endtask

    task automatic rd_row(input logic [15:0] addr, output logic [255:0] data);
        i_state_ena   = 4'hF;
        i_state_wea   = 4'h0;
        i_state_addra = addr;
        tick();
        data          = o_state_dout;
        i_state_ena   = 4'h0;
    endtask

    task automatic run(input string tag);
        int c;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        c = 0;
        while (!o_complete && c < 400) begin
            tick();
            c++;
        end
        check(tag, 256'(o_complete), 256'(1'b1));
    endtask

    initial begin
        logic [255:0] row;
        int c;
        rst_n         = 1'b1;
        i_start       = 1'b1;
        i_qbit_num    = 6'd3;
        i_ctx_en      = 1'b0;
        i_ctx_wea     = 1'b0;
        i_ctx_addr    = '0;
        i_ctx_data    = '0;
        i_state_ena   = '0;
        i_state_wea   = '0;
        i_state_addra = '0;
        i_state_dina  = '0;

        // Reset held three cycles with start asserted throughout
        repeat (3) tick();
        check("rst_complete", 256'(o_complete), 256'(1'b0));
        check("rst_dout", o_state_dout, 256'h0);
        rst_n   = 1'b0;
        i_start = 1'b0;
        repeat (3) tick();
        check("start_in_reset_ignored", 256'(o_complete), 256'(1'b0));

        // Hadamard on q0
        wr_row(16'd0, {ONE, Z, Z, Z});
        wr_row(16'd1, {Z, Z, Z, Z});
        load_gate(64'h1000_0000_0000_0000, HP, HP, HP, HN);
        run("h_done");
        rd_row(16'd0, row);
        check("h_lane0", 256'(row[255:192]), 256'(HP));
        check("h_lane1", 256'(row[191:128]), 256'(HP));
        check("h_lane2", 256'(row[127:64]), 256'(Z));
        check("h_lane3", 256'(row[63:0]), 256'(Z));
        rd_row(16'd1, row);
        check("h_row1", row, 256'h0);

        // Pauli-X on q2: moves amplitude across rows
        wr_row(16'd0, {ONE, Z, Z, Z});
        wr_row(16'd1, {Z, Z, Z, Z});
        load_gate(64'h1002_0000_0000_0000, Z, ONE, ONE, Z);
        run("x_done");
        rd_row(16'd0, row);
        check("x_row0", row, 256'h0);
        rd_row(16'd1, row);
        check("x_row1", row, {ONE, Z, Z, Z});

        // Controlled phase i: control q0, target q1
        wr_row(16'd0, {Z, Z, Z, ONE});
        wr_row(16'd1, {Z, Z, Z, Z});
        load_gate(64'h2001_0000_0000_0000, ONE, Z, Z, IMG);
        run("cp_done");
        rd_row(16'd0, row);
        check("cp_lane3", 256'(row[63:0]), 256'(IMG));
        check("cp_row0", row, {Z, Z, Z, IMG});
        rd_row(16'd1, row);
        check("cp_row1", row, 256'h0);

        // END at address 0: fast completion, state untouched, complete cleared on start
        wr_ctx(16'd0, 64'h0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("end_complete_cleared", 256'(o_complete), 256'(1'b0));
        c = 1;
        while (!o_complete && c < 4) begin
            tick();
            c++;
        end
        check("end_latency", 256'(o_complete), 256'(1'b1));
        rd_row(16'd0, row);
        check("end_state_kept", row, {Z, Z, Z, IMG});

        // Destructive readout: read-first then zero
        i_state_ena   = 4'hF;
        i_state_wea   = 4'hF;
        i_state_addra = 16'd0;
        i_state_dina  = 256'h0;
        tick();
        row           = o_state_dout;
        i_state_ena   = 4'h0;
        i_state_wea   = 4'h0;
        check("readout_first", row, {Z, Z, Z, IMG});
        rd_row(16'd0, row);
        check("readout_cleared", row, 256'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
